d7seg_scan: RTL and testbench

//  Time-multiplexed driver for an NDIG-digit common-anode/cathode 7-segment display.

---
 rtl/d7seg_scan.sv | 146 ++++++++++++++
 tb/tb_d7seg_scan.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/d7seg_scan.sv
// d7seg_scan: time-multiplexed hex driver for an NDIG-digit 7-segment display.
// New values are staged in a pending buffer and committed only when the scan wraps.
module d7seg_scan #(
    parameter int NDIG           = 4,
    parameter int DIV            = 1000,
    parameter int GAP            = 2,
    parameter int LZB            = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [4*NDIG-1:0] value,
    input  logic [NDIG-1:0]   dp_in,
    output logic [6:0]        seg,
    output logic              dp,
    output logic [NDIG-1:0]   an,
    output logic              frame_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_C    = CW'(GAP);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

    logic [CW-1:0]     div_cnt;
    logic [IW-1:0]     idx;
    logic [4*NDIG-1:0] active_val;
    logic [NDIG-1:0]   active_dp;
    logic [4*NDIG-1:0] pending_val;
    logic [NDIG-1:0]   pending_dp;
    logic              pend_v;

    logic              slot_end;
    logic              wrap;
    logic              in_gap;
    logic              blank;
    logic [3:0]        nib;

    logic [6:0]        seg_d, seg_q;
    logic              dp_d, dp_q;
    logic [NDIG-1:0]   an_d, an_q;

    function automatic logic [6:0] font(input logic [3:0] n);
        logic [6:0] f;
        case (n)
            4'h0: f = 7'h7E;
            4'h1: f = 7'h30;
            4'h2: f = 7'h6D;
            4'h3: f = 7'h79;
            4'h4: f = 7'h33;
            4'h5: f = 7'h5B;
            4'h6: f = 7'h5F;
            4'h7: f = 7'h70;
            4'h8: f = 7'h7F;
            4'h9: f = 7'h7B;
            4'hA: f = 7'h77;
            4'hB: f = 7'h1F;
            4'hC: f = 7'h4E;
            4'hD: f = 7'h3D;
            4'hE: f = 7'h4F;
            default: f = 7'h47;
        endcase
        return f;
    endfunction

    assign slot_end = (div_cnt == DIV_LAST);
    assign wrap     = en && slot_end && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            idx     <= '0;
        end else if (en) begin
            if (slot_end) begin
                div_cnt <= '0;
                idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // A load in the wrap cycle itself lands in pending and waits for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_val <= '0;
            pending_dp  <= '0;
            pend_v      <= 1'b0;
            active_val  <= '0;
            active_dp   <= '0;
        end else begin
            if (load) begin
                pending_val <= value;
                pending_dp  <= dp_in;
                pend_v      <= 1'b1;
            end else if (wrap) begin
                pend_v <= 1'b0;
            end
            if (wrap && pend_v) begin
                active_val <= pending_val;
                active_dp  <= pending_dp;
            end
        end
    end

    assign in_gap = (GAP > 0) && (div_cnt < GAP_C);
    assign nib    = active_val[4*idx +: 4];
    assign blank  = (LZB != 0) && (idx != '0) && ((active_val >> (4*idx)) == '0);

    always_comb begin
        seg_d = '0;
        dp_d  = 1'b0;
        an_d  = '0;
        if (en && !in_gap) begin
            an_d[idx] = 1'b1;
            dp_d      = active_dp[idx];
            if (!blank) begin
                seg_d = font(nib);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q      <= '0;
            dp_q       <= 1'b0;
            an_q       <= '0;
            frame_tick <= 1'b0;
        end else begin
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            frame_tick <= wrap;
        end
    end

    // Pin polarity is applied only here; everything upstream is active-high.
    assign seg = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign dp  = (SEG_ACTIVE_LOW != 0) ? ~dp_q  : dp_q;
    assign an  = (AN_ACTIVE_LOW  != 0) ? ~an_q  : an_q;

endmodule

// File: tb/tb_d7seg_scan.sv
// Bench for d7seg_scan (NDIG=4, DIV=8, GAP=2, LZB=1): frame-by-frame checks of every output cycle.
module tb_d7seg_scan;

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    d7seg_scan #(
        .NDIG(4), .DIV(8), .GAP(2), .LZB(1), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .value(value), .dp_in(dp_in),
        .seg(seg), .dp(dp), .an(an), .frame_tick(frame_tick)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       ft;
    } exp_t;

    typedef struct packed {
        logic [15:0]     value;
        logic [3:0]      dpv;
        int              ld_at;
        logic [3:0][6:0] eseg;
        logic [3:0]      edp;
    } vec_t;

    exp_t  exp_q[$];
    string nm_q[$];
    int    total = 0;
    int    bad   = 0;
    vec_t  recs[6];

    localparam logic [3:0][6:0] ZERO_SEG = {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110};
    localparam logic [3:0][6:0] SEG_89AB = {7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111};
    localparam logic [3:0][6:0] SEG_CDEF = {7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic expect_cycle(input logic [3:0] ean, input logic [6:0] eseg,
                                input logic edp, input logic eft, input string nm);
        exp_t  e;
        exp_t  got;
        string n;
        exp_q.push_back('{an: ean, seg: eseg, dp: edp, ft: eft});
        nm_q.push_back(nm);
        @(negedge clk);
        e   = exp_q.pop_front();
        n   = nm_q.pop_front();
        got = '{an: an, seg: seg, dp: dp, ft: frame_tick};
        total++;
        if (got !== e) begin
            bad++;
            $display("FAIL %s: got an=%b seg=%b dp=%b ft=%b, expected an=%b seg=%b dp=%b ft=%b",
                     n, got.an, got.seg, got.dp, got.ft, e.an, e.seg, e.dp, e.ft);
        end
    endtask

    // Runs one frame starting at a cycle where the scan counter is at slot 0, count 0.
    // Returns at the next frame_tick cycle, or right after a reset pulse when rst_at is hit.
    task automatic check_frame(input string nm, input logic [3:0][6:0] es, input logic [3:0] edpv,
                               input int l1, input logic [15:0] v1, input logic [3:0] p1,
                               input int l2, input logic [15:0] v2, input logic [3:0] p2,
                               input int off_at, input int rst_at);
        int         cnt;
        int         d;
        int         k;
        logic [3:0] ean;
        logic [6:0] ese;
        logic       ed;
        logic       ef;
        cnt = 0;
        for (int j = 0; j < 64; j++) begin
            rst  = 1'b0;
            load = 1'b0;
            if (j == l1) begin load = 1'b1; value = v1; dp_in = p1; end
            if (j == l2) begin load = 1'b1; value = v2; dp_in = p2; end
            en = !(off_at >= 0 && j >= off_at && j < off_at + 5);
            if (j == rst_at) begin
                rst = 1'b1;
                expect_cycle(4'b1111, 7'b0, 1'b0, 1'b0, $sformatf("%s rst j=%0d", nm, j));
                rst  = 1'b0;
                load = 1'b0;
                return;
            end
            ean = 4'b1111;
            ese = 7'b0;
            ed  = 1'b0;
            ef  = 1'b0;
            if (en) begin
                d = cnt / 8;
                k = cnt % 8;
                if (k >= 2) begin
                    ean = ~(4'b0001 << d);
                    ese = es[d];
                    ed  = edpv[d];
                end
                ef = (cnt == 31);
            end
            expect_cycle(ean, ese, ed, ef, $sformatf("%s j=%0d", nm, j));
            if (en) cnt++;
            if (cnt == 32) return;
        end
    endtask

    initial begin
        recs[0] = '{value: 16'h12AF, dpv: 4'b0000, ld_at: 0,
                    eseg: {7'b0110000, 7'b1101101, 7'b1110111, 7'b1000111}, edp: 4'b0000};
        recs[1] = '{value: 16'h0050, dpv: 4'b0000, ld_at: 0,
                    eseg: {7'b0000000, 7'b0000000, 7'b1011011, 7'b1111110}, edp: 4'b0000};
        recs[2] = '{value: 16'h0000, dpv: 4'b0100, ld_at: 7,
                    eseg: {7'b0000000, 7'b0000000, 7'b0000000, 7'b1111110}, edp: 4'b0100};
        recs[3] = '{value: 16'h8003, dpv: 4'b1001, ld_at: 20,
                    eseg: {7'b1111111, 7'b1111110, 7'b1111110, 7'b1111001}, edp: 4'b1001};
        recs[4] = '{value: 16'h0D0C, dpv: 4'b0000, ld_at: 25,
                    eseg: {7'b0000000, 7'b0111101, 7'b1111110, 7'b1001110}, edp: 4'b0000};
        recs[5] = '{value: 16'h1111, dpv: 4'b0000, ld_at: 12,
                    eseg: {7'b0110000, 7'b0110000, 7'b0110000, 7'b0110000}, edp: 4'b0000};

        rst   = 1'b1;
        en    = 1'b1;
        load  = 1'b0;
        value = 16'h0;
        dp_in = 4'h0;
        repeat (3) @(negedge clk);
        expect_cycle(4'b1111, 7'b0, 1'b0, 1'b0, "reset");

        // frame 1 shows the reset contents while the first value waits in pending
        check_frame("zero", ZERO_SEG, 4'b0000, recs[0].ld_at, recs[0].value, recs[0].dpv,
                    -1, 16'h0, 4'h0, -1, -1);

        for (int i = 0; i < 6; i++) begin
            if (i < 5)
                check_frame($sformatf("rec%0d", i), recs[i].eseg, recs[i].edp,
                            recs[i+1].ld_at, recs[i+1].value, recs[i+1].dpv,
                            -1, 16'h0, 4'h0, -1, -1);
            else
                check_frame("rec5 en_off", recs[i].eseg, recs[i].edp,
                            5, 16'h4567, 4'b0000, 12, 16'h89AB, 4'b0010, 10, -1);
        end

        check_frame("last_wins", SEG_89AB, 4'b0010, 31, 16'hCDEF, 4'b0000,
                    -1, 16'h0, 4'h0, -1, -1);
        check_frame("wrap_load_deferred", SEG_89AB, 4'b0010, -1, 16'h0, 4'h0,
                    -1, 16'h0, 4'h0, -1, -1);
        check_frame("cdef_rst", SEG_CDEF, 4'b0000, 3, 16'h1234, 4'b0000,
                    -1, 16'h0, 4'h0, -1, 18);
        check_frame("after_rst", ZERO_SEG, 4'b0000, -1, 16'h0, 4'h0,
                    -1, 16'h0, 4'h0, -1, -1);
        check_frame("pend_dropped", ZERO_SEG, 4'b0000, -1, 16'h0, 4'h0,
                    -1, 16'h0, 4'h0, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
